// File: rtl/sram_arb_pkg.sv
// Shared types and constants for the SRAM port arbiter: owner state
// encoding, default hold limit and the hold-counter width helper.
package sram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    OWN0 = 2'b01,
    OWN1 = 2'b10
  } owner_e;

  localparam int MAX_HOLD_DEF = 8;

  // Ceiling log2; never returns less than 1 so counters keep a real bit.
  function automatic int clog2(input int value);
    int w;
    w = 1;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 << i) < value) begin
        w = i + 1;
      end
    end
    return w;
  endfunction

  // Width of a counter that must hold values 0..max_hold inclusive.
  function automatic int hold_cnt_width(input int max_hold);
    return clog2(max_hold + 1);
  endfunction

endpackage

// File: rtl/sram_arb_pick.sv
// Combinational grant picker: single requester wins outright, a locked
// owner keeps the port while under its hold limit, otherwise round-robin.
module sram_arb_pick
  import sram_arb_pkg::*;
#(
  parameter int MAX_HOLD = MAX_HOLD_DEF,
  parameter int HOLD_W   = hold_cnt_width(MAX_HOLD_DEF)
) (
  input  logic [1:0]        req,
  input  logic [1:0]        lock,
  input  owner_e            owner,
  input  logic              last,
  input  logic [HOLD_W-1:0] hold_cnt,
  output logic [1:0]        gnt
);

  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD);

  logic hold_ok_s;

  assign hold_ok_s = (hold_cnt < HOLD_MAX);

  // Grant decision: at most one bit set, and only for a requesting side.
  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b00: gnt = 2'b00;
      2'b01: gnt = 2'b01;
      2'b10: gnt = 2'b10;
      2'b11: begin
        if ((owner == OWN0) && lock[0] && hold_ok_s) begin
          gnt = 2'b01;
        end else if ((owner == OWN1) && lock[1] && hold_ok_s) begin
          gnt = 2'b10;
        end else if (last == 1'b1) begin
          gnt = 2'b01;
        end else begin
          gnt = 2'b10;
        end
      end
      default: gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/sram_port_arbiter.sv
// Two-requester arbiter for one SRAM port: zero-latency grant, lock-based
// burst holding bounded by MAX_HOLD, and 1-cycle read data routed back to
// whichever requester issued the read.
module sram_port_arbiter
  import sram_arb_pkg::*;
#(
  parameter int AW       = 13,
  parameter int DW       = 32,
  parameter int MAX_HOLD = MAX_HOLD_DEF
) (
  input  logic            SRAMHCLK,
  input  logic            SRAMHRESET,
  input  logic            REQ0,
  input  logic            LOCK0,
  input  logic [AW-1:0]   ADDR0,
  input  logic [DW/8-1:0] WREN0,
  input  logic [DW-1:0]   WDATA0,
  input  logic            REQ1,
  input  logic            LOCK1,
  input  logic [AW-1:0]   ADDR1,
  input  logic [DW/8-1:0] WREN1,
  input  logic [DW-1:0]   WDATA1,
  output logic            GNT0,
  output logic            GNT1,
  output logic            RVALID0,
  output logic            RVALID1,
  output logic [DW-1:0]   RDATA0,
  output logic [DW-1:0]   RDATA1,
  output logic [AW-1:0]   SRAMADDR,
  output logic [DW/8-1:0] SRAMWREN,
  output logic [DW-1:0]   SRAMWDATA,
  output logic            SRAMCS,
  input  logic [DW-1:0]   SRAMRDATA
);

  localparam int BW     = DW / 8;
  localparam int HOLD_W = hold_cnt_width(MAX_HOLD);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD);
  localparam logic [HOLD_W-1:0] HOLD_ONE = HOLD_W'(1);

  owner_e              owner_r;
  owner_e              owner_nxt_s;
  logic                last_r;
  logic                last_nxt_s;
  logic [HOLD_W-1:0]   hold_r;
  logic [HOLD_W-1:0]   hold_nxt_s;
  logic                rd_pend_r;
  logic                rd_tag_r;
  logic                rd_issue_s;
  logic [1:0]          pick_gnt_s;
  logic [1:0]          gnt_s;
  logic [AW-1:0]       addr_s;
  logic [BW-1:0]       wren_s;
  logic [DW-1:0]       wdata_s;
  logic                cs_s;

  sram_arb_pick #(
    .MAX_HOLD (MAX_HOLD),
    .HOLD_W   (HOLD_W)
  ) u_pick (
    .req      ({REQ1, REQ0}),
    .lock     ({LOCK1, LOCK0}),
    .owner    (owner_r),
    .last     (last_r),
    .hold_cnt (hold_r),
    .gnt      (pick_gnt_s)
  );

  // Requests are ignored while reset is held.
  assign gnt_s = pick_gnt_s & {2{~SRAMHRESET}};
  assign GNT0  = gnt_s[0];
  assign GNT1  = gnt_s[1];

  // Port mux: granted requester drives the SRAM, otherwise everything is 0.
  always_comb begin
    addr_s  = {AW{1'b0}};
    wren_s  = {BW{1'b0}};
    wdata_s = {DW{1'b0}};
    cs_s    = 1'b0;
    case (gnt_s)
      2'b01: begin
        addr_s  = ADDR0;
        wren_s  = WREN0;
        wdata_s = WDATA0;
        cs_s    = 1'b1;
      end
      2'b10: begin
        addr_s  = ADDR1;
        wren_s  = WREN1;
        wdata_s = WDATA1;
        cs_s    = 1'b1;
      end
      default: begin
        addr_s  = {AW{1'b0}};
        wren_s  = {BW{1'b0}};
        wdata_s = {DW{1'b0}};
        cs_s    = 1'b0;
      end
    endcase
  end

  assign SRAMADDR  = addr_s;
  assign SRAMWREN  = wren_s;
  assign SRAMWDATA = wdata_s;
  assign SRAMCS    = cs_s;

  assign rd_issue_s = cs_s && (wren_s == {BW{1'b0}});

  // Next owner and round-robin pointer follow whoever is granted now.
  always_comb begin
    owner_nxt_s = IDLE;
    last_nxt_s  = last_r;
    case (gnt_s)
      2'b01: begin
        owner_nxt_s = OWN0;
        last_nxt_s  = 1'b0;
      end
      2'b10: begin
        owner_nxt_s = OWN1;
        last_nxt_s  = 1'b1;
      end
      default: begin
        owner_nxt_s = IDLE;
        last_nxt_s  = last_r;
      end
    endcase
  end

  // Hold counter: counts repeat grants to the same owner while the other
  // side waits; any break in that pattern restarts it.
  always_comb begin
    hold_nxt_s = {HOLD_W{1'b0}};
    if ((gnt_s[0] && (owner_r == OWN0) && REQ1) ||
        (gnt_s[1] && (owner_r == OWN1) && REQ0)) begin
      if (hold_r == HOLD_MAX) begin
        hold_nxt_s = hold_r;
      end else begin
        hold_nxt_s = hold_r + HOLD_ONE;
      end
    end else begin
      hold_nxt_s = {HOLD_W{1'b0}};
    end
  end

  // Arbitration state and read-tag pipeline registers.
  always_ff @(posedge SRAMHCLK or posedge SRAMHRESET) begin
    if (SRAMHRESET) begin
      owner_r   <= IDLE;
      last_r    <= 1'b1;
      hold_r    <= {HOLD_W{1'b0}};
      rd_pend_r <= 1'b0;
      rd_tag_r  <= 1'b0;
    end else begin
      owner_r   <= owner_nxt_s;
      last_r    <= last_nxt_s;
      hold_r    <= hold_nxt_s;
      rd_pend_r <= rd_issue_s;
      if (rd_issue_s) begin
        rd_tag_r <= gnt_s[1];
      end else begin
        rd_tag_r <= rd_tag_r;
      end
    end
  end

  assign RVALID0 = rd_pend_r && (rd_tag_r == 1'b0);
  assign RVALID1 = rd_pend_r && (rd_tag_r == 1'b1);
  assign RDATA0  = RVALID0 ? SRAMRDATA : {DW{1'b0}};
  assign RDATA1  = RVALID1 ? SRAMRDATA : {DW{1'b0}};

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter with a behavioural 1-cycle SRAM.
module tb_sram_port_arbiter;

  logic        SRAMHCLK;
  logic        SRAMHRESET;
  logic        REQ0, LOCK0, REQ1, LOCK1;
  logic [12:0] ADDR0, ADDR1;
  logic [3:0]  WREN0, WREN1;
  logic [31:0] WDATA0, WDATA1;
  logic        GNT0, GNT1, RVALID0, RVALID1;
  logic [31:0] RDATA0, RDATA1;
  logic [12:0] SRAMADDR;
  logic [3:0]  SRAMWREN;
  logic [31:0] SRAMWDATA;
  logic        SRAMCS;
  logic [31:0] SRAMRDATA;

  logic [31:0] mem [0:8191];
  int checks;
  int failures;

  sram_port_arbiter dut (
    .SRAMHCLK(SRAMHCLK), .SRAMHRESET(SRAMHRESET),
    .REQ0(REQ0), .LOCK0(LOCK0), .ADDR0(ADDR0), .WREN0(WREN0), .WDATA0(WDATA0),
    .REQ1(REQ1), .LOCK1(LOCK1), .ADDR1(ADDR1), .WREN1(WREN1), .WDATA1(WDATA1),
    .GNT0(GNT0), .GNT1(GNT1), .RVALID0(RVALID0), .RVALID1(RVALID1),
    .RDATA0(RDATA0), .RDATA1(RDATA1),
    .SRAMADDR(SRAMADDR), .SRAMWREN(SRAMWREN), .SRAMWDATA(SRAMWDATA),
    .SRAMCS(SRAMCS), .SRAMRDATA(SRAMRDATA)
  );

  initial SRAMHCLK = 1'b0;
  always #5 SRAMHCLK = ~SRAMHCLK;

  // SRAM model: byte-masked writes, read data one cycle after the access.
  always @(posedge SRAMHCLK) begin
    if (SRAMCS) begin
      if (SRAMWREN != 4'h0) begin
        for (int b = 0; b < 4; b++) begin
          if (SRAMWREN[b]) mem[SRAMADDR][8*b +: 8] <= SRAMWDATA[8*b +: 8];
        end
      end else begin
        SRAMRDATA <= mem[SRAMADDR];
      end
    end
  end

  task automatic step();
    @(posedge SRAMHCLK);
    #1;
  endtask

  task automatic clear_inputs();
    REQ0 = 1'b0; LOCK0 = 1'b0; ADDR0 = 13'h0000; WREN0 = 4'h0; WDATA0 = 32'h0;
    REQ1 = 1'b0; LOCK1 = 1'b0; ADDR1 = 13'h0000; WREN1 = 4'h0; WDATA1 = 32'h0;
  endtask

  task automatic apply_reset();
    clear_inputs();
    SRAMHRESET = 1'b1;
    step();
    step();
    SRAMHRESET = 1'b0;
  endtask

  task automatic test_reset();
    SRAMHRESET = 1'b1;
    REQ0 = 1'b1; REQ1 = 1'b1; ADDR0 = 13'h0001; WREN0 = 4'hF; WDATA0 = 32'h1111_2222;
    @(negedge SRAMHCLK);
    checks++; if (GNT0 !== 1'b0) begin failures++; $display("FAIL reset_gnt0 got=%0h exp=0", GNT0); end
    checks++; if (GNT1 !== 1'b0) begin failures++; $display("FAIL reset_gnt1 got=%0h exp=0", GNT1); end
    checks++; if (SRAMCS !== 1'b0) begin failures++; $display("FAIL reset_cs got=%0h exp=0", SRAMCS); end
    checks++; if (SRAMADDR !== 13'h0000) begin failures++; $display("FAIL reset_addr got=%h exp=0000", SRAMADDR); end
    checks++; if (SRAMWREN !== 4'h0) begin failures++; $display("FAIL reset_wren got=%h exp=0", SRAMWREN); end
    checks++; if (SRAMWDATA !== 32'h0) begin failures++; $display("FAIL reset_wdata got=%h exp=0", SRAMWDATA); end
    checks++; if ({RVALID1, RVALID0} !== 2'b00) begin failures++; $display("FAIL reset_rvalid got=%b exp=00", {RVALID1, RVALID0}); end
    checks++; if ({RDATA1, RDATA0} !== 64'h0) begin failures++; $display("FAIL reset_rdata got=%h exp=0", {RDATA1, RDATA0}); end
    step();
    clear_inputs();
    SRAMHRESET = 1'b0;
  endtask

  task automatic test_write_read();
    REQ0 = 1'b1; ADDR0 = 13'h0010; WREN0 = 4'hF; WDATA0 = 32'hDEAD_BEEF;
    @(negedge SRAMHCLK);
    checks++; if ({GNT1, GNT0} !== 2'b01) begin failures++; $display("FAIL wr_gnt got=%b exp=01", {GNT1, GNT0}); end
    checks++; if (SRAMCS !== 1'b1) begin failures++; $display("FAIL wr_cs got=%0h exp=1", SRAMCS); end
    checks++; if (SRAMADDR !== 13'h0010) begin failures++; $display("FAIL wr_addr got=%h exp=0010", SRAMADDR); end
    checks++; if (SRAMWDATA !== 32'hDEAD_BEEF) begin failures++; $display("FAIL wr_wdata got=%h exp=deadbeef", SRAMWDATA); end
    step();
    WREN0 = 4'h0; WDATA0 = 32'h0;
    @(negedge SRAMHCLK);
    checks++; if ({GNT1, GNT0} !== 2'b01) begin failures++; $display("FAIL rd_gnt got=%b exp=01", {GNT1, GNT0}); end
    checks++; if (SRAMWREN !== 4'h0) begin failures++; $display("FAIL rd_wren got=%h exp=0", SRAMWREN); end
    step();
    clear_inputs();
    @(negedge SRAMHCLK);
    checks++; if (RVALID0 !== 1'b1) begin failures++; $display("FAIL rd_rvalid0 got=%0h exp=1", RVALID0); end
    checks++; if (RDATA0 !== 32'hDEAD_BEEF) begin failures++; $display("FAIL rd_rdata0 got=%h exp=deadbeef", RDATA0); end
    checks++; if (RVALID1 !== 1'b0) begin failures++; $display("FAIL rd_rvalid1 got=%0h exp=0", RVALID1); end
    checks++; if (SRAMCS !== 1'b0) begin failures++; $display("FAIL idle_cs got=%0h exp=0", SRAMCS); end
    step();
    @(negedge SRAMHCLK);
    checks++; if (RVALID0 !== 1'b0) begin failures++; $display("FAIL rd_rvalid0_drop got=%0h exp=0", RVALID0); end
    step();
  endtask

  task automatic test_round_robin();
    logic exp0;
    apply_reset();
    for (int k = 0; k < 6; k++) begin
      REQ0 = 1'b1; REQ1 = 1'b1; WREN0 = 4'h0; WREN1 = 4'h0;
      ADDR0 = 13'h0100 + 13'(k); ADDR1 = 13'h0200 + 13'(k);
      exp0 = ((k % 2) == 0);
      @(negedge SRAMHCLK);
      checks++; if ({GNT1, GNT0} !== {~exp0, exp0}) begin failures++; $display("FAIL rr_gnt[%0d] got=%b exp=%b", k, {GNT1, GNT0}, {~exp0, exp0}); end
      checks++; if (SRAMADDR !== (exp0 ? ADDR0 : ADDR1)) begin failures++; $display("FAIL rr_addr[%0d] got=%h exp=%h", k, SRAMADDR, exp0 ? ADDR0 : ADDR1); end
      if (k > 0) begin
        checks++; if ({RVALID1, RVALID0} !== {exp0, ~exp0}) begin failures++; $display("FAIL rr_rvalid[%0d] got=%b exp=%b", k, {RVALID1, RVALID0}, {exp0, ~exp0}); end
      end
      step();
    end
    clear_inputs();
    step();
  endtask

  task automatic test_lock_burst();
    logic exp0;
    clear_inputs();
    step();
    for (int c = 0; c < 20; c++) begin
      REQ1 = 1'b1; LOCK1 = 1'b1; ADDR1 = 13'h0300; REQ0 = (c > 0); ADDR0 = 13'h0400;
      exp0 = (c == 9) || (c == 19);
      @(negedge SRAMHCLK);
      checks++; if ({GNT1, GNT0} !== {~exp0, exp0}) begin failures++; $display("FAIL lock_gnt[%0d] got=%b exp=%b", c, {GNT1, GNT0}, {~exp0, exp0}); end
      step();
    end
    clear_inputs();
    step();
  endtask

  task automatic test_cross_rw();
    REQ1 = 1'b1; ADDR1 = 13'h1FFF; WREN1 = 4'hF; WDATA1 = 32'h1234_5678;
    @(negedge SRAMHCLK);
    checks++; if ({GNT1, GNT0} !== 2'b10) begin failures++; $display("FAIL xrw_wgnt got=%b exp=10", {GNT1, GNT0}); end
    step();
    clear_inputs();
    REQ0 = 1'b1; ADDR0 = 13'h1FFF;
    @(negedge SRAMHCLK);
    checks++; if ({GNT1, GNT0} !== 2'b01) begin failures++; $display("FAIL xrw_rgnt got=%b exp=01", {GNT1, GNT0}); end
    step();
    clear_inputs();
    @(negedge SRAMHCLK);
    checks++; if ({RVALID1, RVALID0} !== 2'b01) begin failures++; $display("FAIL xrw_rvalid got=%b exp=01", {RVALID1, RVALID0}); end
    checks++; if (RDATA0 !== 32'h1234_5678) begin failures++; $display("FAIL xrw_rdata0 got=%h exp=12345678", RDATA0); end
    step();
  endtask

  task automatic test_reset_pending();
    REQ1 = 1'b1; ADDR1 = 13'h1FFF;
    @(negedge SRAMHCLK);
    checks++; if ({GNT1, GNT0} !== 2'b10) begin failures++; $display("FAIL rstp_gnt got=%b exp=10", {GNT1, GNT0}); end
    step();
    clear_inputs();
    SRAMHRESET = 1'b1;
    @(negedge SRAMHCLK);
    checks++; if (RVALID1 !== 1'b0) begin failures++; $display("FAIL rstp_rvalid1_in got=%0h exp=0", RVALID1); end
    checks++; if (RDATA1 !== 32'h0) begin failures++; $display("FAIL rstp_rdata1_in got=%h exp=0", RDATA1); end
    step();
    SRAMHRESET = 1'b0;
    REQ0 = 1'b1; REQ1 = 1'b1;
    @(negedge SRAMHCLK);
    checks++; if (RVALID1 !== 1'b0) begin failures++; $display("FAIL rstp_rvalid1_after got=%0h exp=0", RVALID1); end
    checks++; if ({GNT1, GNT0} !== 2'b01) begin failures++; $display("FAIL rstp_tie got=%b exp=01", {GNT1, GNT0}); end
    step();
    clear_inputs();
    step();
  endtask

  task automatic test_byte_write();
    REQ0 = 1'b1; ADDR0 = 13'h0020; WREN0 = 4'hF; WDATA0 = 32'h0000_0000;
    step();
    WREN0 = 4'b0100; WDATA0 = 32'hAABB_CCDD;
    @(negedge SRAMHCLK);
    checks++; if (SRAMWREN !== 4'b0100) begin failures++; $display("FAIL bw_wren got=%b exp=0100", SRAMWREN); end
    step();
    WREN0 = 4'h0; WDATA0 = 32'h0;
    step();
    clear_inputs();
    @(negedge SRAMHCLK);
    checks++; if (RVALID0 !== 1'b1) begin failures++; $display("FAIL bw_rvalid0 got=%0h exp=1", RVALID0); end
    checks++; if (RDATA0 !== 32'h00BB_0000) begin failures++; $display("FAIL bw_rdata0 got=%h exp=00bb0000", RDATA0); end
    step();
  endtask

  task automatic test_lock_no_req();
    LOCK0 = 1'b1; ADDR0 = 13'h0AAA; WDATA0 = 32'h5555_AAAA; WREN0 = 4'hF;
    REQ1 = 1'b1; ADDR1 = 13'h0055;
    @(negedge SRAMHCLK);
    checks++; if ({GNT1, GNT0} !== 2'b10) begin failures++; $display("FAIL lnr_gnt got=%b exp=10", {GNT1, GNT0}); end
    checks++; if (SRAMADDR !== 13'h0055) begin failures++; $display("FAIL lnr_addr got=%h exp=0055", SRAMADDR); end
    step();
    REQ1 = 1'b0;
    @(negedge SRAMHCLK);
    checks++; if ({GNT1, GNT0} !== 2'b00) begin failures++; $display("FAIL idle_gnt got=%b exp=00", {GNT1, GNT0}); end
    checks++; if ({SRAMCS, SRAMADDR, SRAMWREN, SRAMWDATA} !== 50'h0) begin failures++; $display("FAIL idle_port got=%h exp=0", {SRAMCS, SRAMADDR, SRAMWREN, SRAMWDATA}); end
    step();
    clear_inputs();
  endtask

  initial begin
    checks = 0;
    failures = 0;
    SRAMRDATA = 32'h0;
    for (int i = 0; i < 8192; i++) mem[i] = 32'h0;
    clear_inputs();
    SRAMHRESET = 1'b1;
    test_reset();
    test_write_read();
    test_round_robin();
    test_lock_burst();
    test_cross_rw();
    test_reset_pending();
    test_byte_write();
    test_lock_no_req();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sram_port_arbiter.md
# sram_port_arbiter

Two-requester arbiter sharing one SRAM bank-pair port (13-bit word address, 4-bit byte write enables, 32-bit data) between the CPU-side AHB2SRAM bridge (requester 0) and the DMA engine (requester 1). It sits between the requesters and the SRAM subsystem port. Grants are issued with zero-cycle latency. It supports lock-based burst holding, bounded by a starvation limit, with round-robin tie-break, and it routes 1-cycle-latency read data back to the originating requester.

## Interface
- AW, 13: SRAM word address width.
- DW, 32: data width; byte enables are DW/8.
- MAX_HOLD, 8: maximum consecutive grants to a locked owner while the other requester waits; range 1..255.
- SRAMHCLK  in  1  single clock. One clock; reset is asynchronous and active-high.
- SRAMHRESET  in  1  asynchronous, active-high reset.
- REQ0 / REQ1  in  1  access request, held until granted.
- LOCK0 / LOCK1  in  1  request to keep ownership on the next cycle (burst).
- ADDR0 / ADDR1  in  AW  word address.
- WREN0 / WREN1  in  DW/8  byte write enables; all-zero means read.
- WDATA0 / WDATA1  in  DW  write data.
- GNT0 / GNT1  out  1  access accepted this cycle (combinational).
- RVALID0 / RVALID1  out  1  RDATAx holds read data for that requester's read accepted last cycle.
- RDATA0 / RDATA1  out  DW  read data.
- SRAMADDR  out  AW  to SRAM port.
- SRAMWREN  out  DW/8  to SRAM port.
- SRAMWDATA  out  DW  to SRAM port.
- SRAMCS  out  1  to SRAM port.
- SRAMRDATA  in  DW  from SRAM port; valid the cycle after a read access.

## Operation

**Arbitration state**
- The owner register is one of IDLE, OWN0 or OWN1 and records who was granted last cycle.
- A `last` pointer records who was most recently granted; it resets to 1, so requester 0 wins the first tie.
- hold_cnt counts consecutive contested grants to the current owner.

**Grant decision** (each cycle, combinational on registered state and inputs)
- Neither REQx: no grant.
- Exactly one REQx: grant it.
- Both REQx, owner OWNk with LOCKk=1 and hold_cnt < MAX_HOLD: grant k.
- Both REQx, otherwise: grant the requester not equal to `last` (round-robin).
- At most one GNTx is high per cycle. GNTx implies REQx.

**Access**
- On GNTx: SRAMCS=1, and SRAMADDR/SRAMWREN/SRAMWDATA = ADDRx/WRENx/WDATAx.
- With no grant: SRAMCS=0 and the other port outputs are driven to 0.

**Registered updates at the edge**
- owner ← OWNx on GNTx, else IDLE; `last` ← x on GNTx.
- hold_cnt increments, saturating at MAX_HOLD, when granting the same owner while the other requests. It clears to 0 on owner change, on an idle cycle, or when the other requester is not requesting.

**Read return**
- On a granted read (WRENx == 0), rd_tag ← x and rd_pend ← 1.
- Next cycle, RVALIDx = rd_pend && rd_tag==x.
- RDATAx = SRAMRDATA when RVALIDx is high, else 0.

**Reset values**
- owner=IDLE, last=1, hold_cnt=0, rd_pend=0.
- Consequently GNT0/1=0, RVALID0/1=0, RDATA0/1=0, SRAMCS=0 and SRAM outputs 0 while SRAMHRESET is high; requests are ignored during reset.

**Boundary conditions**
- LOCKx without REQx has no effect.
- LOCK on the non-owner has no effect.
- A hold limit reached with the other requester waiting forces a switch, even if LOCK remains asserted.
- Reset asserted with a read pending: the read data is discarded, and RVALID does not fire after release.

## Timing
- Grant latency: 0 cycles (same cycle as REQ when uncontested).
- Read latency: RVALID/RDATA are asserted exactly 1 cycle after the granted read cycle.
- Writes commit at the edge ending the grant cycle.
- Throughput: one access per cycle; back-to-back and alternating requesters are both allowed with no bubble.
- A read issued by one requester in cycle n+1, to an address written by the other in cycle n, returns the new data in cycle n+2.

## Structure
- Package sram_arb_pkg:
  - owner state encoding (IDLE=2'b00, OWN0=2'b01, OWN1=2'b10);
  - the MAX_HOLD default;
  - hold-counter width function clog2(MAX_HOLD+1).
- One natural sub-module: sram_arb_pick, purely combinational. It takes REQ/LOCK, owner, `last` and hold_cnt, and outputs the one-hot grant. It is instantiated once.
- Everything else (owner/last/hold registers, read-tag pipeline, port mux) lives in the top.

## Test plan
- Reset, then REQ0 alone with a write to address 0x0010 of 0xDEADBEEF (WREN 0xF): GNT0 in the same cycle, SRAMCS=1, SRAMADDR=0x0010. A following REQ0 read of 0x0010 gives RVALID0=1 one cycle later with RDATA0=0xDEADBEEF, and RVALID1 stays 0.
- REQ0 and REQ1 both held continuously, no LOCK: grants alternate 0,1,0,1… starting with 0 after reset.
- REQ1 with LOCK1 held for a 20-cycle burst, REQ0 waiting with MAX_HOLD=8: GNT1 for 8 contested cycles, then one GNT0, then GNT1 resumes.
- Requester 1 writes 0x1FFF=0x12345678 in cycle n; requester 0 reads 0x1FFF in cycle n+1: RVALID0 and RDATA0=0x12345678 in cycle n+2.
- SRAMHRESET pulsed the cycle after a granted read by requester 1: RVALID1 stays 0; owner is IDLE and the next tie grants requester 0.
- Byte write with WREN0=4'b0100 and WDATA 0xAABBCCDD over 0x00000000, then a read: RDATA0=0x00BB0000.
